// File: rtl/nand_seq_pkg.sv
// Shared types and constants for the bit-serial NAND adder.
package nand_seq_pkg;

  // Controller states: wait for a request, walk the NAND steps, report once.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  // Gate evaluations needed to produce one sum bit and its carry.
  localparam int NAND_STEPS = 9;

  // Width of the step counter (holds 0..NAND_STEPS-1).
  localparam int STEP_W = 4;

  // Index of the final step of a bit (the carry update).
  localparam logic [STEP_W-1:0] LAST_STEP = 4'd8;

  // Bit-counter width for a given operand width; never narrower than one bit.
  function automatic int idx_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/nand_seq_adder_nand_unit.sv
// The single shared 2-input NAND evaluator. Operands arrive as zero-extended
// single bits, so only the LSBs take part in the result.
module nand_unit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic       o_y
);

  logic w_unused_hi;

  assign o_y = ~(i_a[0] & i_b[0]);

  // Upper bits are always zero by construction.
  assign w_unused_hi = &{1'b0, i_a[3:1], i_b[3:1]};

endmodule

// File: rtl/nand_seq_adder.sv
// Bit-serial ripple adder built from one time-shared NAND gate: each sum bit
// costs nine gate evaluations, one per clock.
// Optional feature: define NAND_SEQ_SUB_EN to add the 'sub' input
// (a - b via inverted b and forced carry-in).
module nand_seq_adder
  import nand_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef NAND_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int BIT_W = idx_w(WIDTH);

  state_t             r_state;
  state_t             w_next_state;
  logic [STEP_W-1:0]  r_step;
  logic [BIT_W-1:0]   r_bit;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_c;
  logic               r_n1, r_n2, r_n3, r_x, r_n5, r_n6, r_n7;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_busy;
  logic               r_done;

  logic [WIDTH-1:0]   w_b_eff;
  logic               w_cin_eff;
  logic               w_a_i;
  logic               w_b_i;
  logic               w_op_a;
  logic               w_op_b;
  logic               w_nand;
  logic               w_last_step;
  logic               w_last_bit;

`ifdef NAND_SEQ_SUB_EN
  // Subtraction is a + ~b + 1, so the transform is applied as operands latch.
  assign w_b_eff   = sub ? ~b : b;
  assign w_cin_eff = sub ? 1'b1 : c_in;
`else
  assign w_b_eff   = b;
  assign w_cin_eff = c_in;
`endif

  assign w_a_i       = r_a[r_bit];
  assign w_b_i       = r_b[r_bit];
  assign w_last_step = (r_step == LAST_STEP);
  assign w_last_bit  = (r_bit == BIT_W'(WIDTH - 1));

  nand_unit u_nand (
    .i_a ({3'b000, w_op_a}),
    .i_b ({3'b000, w_op_b}),
    .o_y (w_nand)
  );

  // Route the operands of the current step into the shared gate.
  always_comb begin
    w_op_a = 1'b0;
    w_op_b = 1'b0;
    case (r_step)
      4'd0:    begin w_op_a = w_a_i; w_op_b = w_b_i; end
      4'd1:    begin w_op_a = w_a_i; w_op_b = r_n1;  end
      4'd2:    begin w_op_a = w_b_i; w_op_b = r_n1;  end
      4'd3:    begin w_op_a = r_n2;  w_op_b = r_n3;  end
      4'd4:    begin w_op_a = r_x;   w_op_b = r_c;   end
      4'd5:    begin w_op_a = r_x;   w_op_b = r_n5;  end
      4'd6:    begin w_op_a = r_c;   w_op_b = r_n5;  end
      4'd7:    begin w_op_a = r_n6;  w_op_b = r_n7;  end
      4'd8:    begin w_op_a = r_n1;  w_op_b = r_n5;  end
      default: begin w_op_a = 1'b0;  w_op_b = 1'b0;  end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic: start only matters in IDLE, DONE always lasts one cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (start) w_next_state = EVAL;
        else       w_next_state = IDLE;
      end
      EVAL: begin
        if (w_last_step && w_last_bit) w_next_state = DONE;
        else                           w_next_state = EVAL;
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: operand capture, step/bit counting, scratch and result updates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_step <= '0;
      r_bit  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= 1'b0;
      r_n1   <= 1'b0;
      r_n2   <= 1'b0;
      r_n3   <= 1'b0;
      r_x    <= 1'b0;
      r_n5   <= 1'b0;
      r_n6   <= 1'b0;
      r_n7   <= 1'b0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      // done trails the DONE state by one edge so it lands after busy drops.
      r_done <= (r_state == DONE);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a    <= a;
            r_b    <= w_b_eff;
            r_c    <= w_cin_eff;
            r_step <= '0;
            r_bit  <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_busy <= 1'b1;
          end else begin
            r_busy <= 1'b0;
          end
        end
        EVAL: begin
          case (r_step)
            4'd0:    r_n1         <= w_nand;
            4'd1:    r_n2         <= w_nand;
            4'd2:    r_n3         <= w_nand;
            4'd3:    r_x          <= w_nand;
            4'd4:    r_n5         <= w_nand;
            4'd5:    r_n6         <= w_nand;
            4'd6:    r_n7         <= w_nand;
            4'd7:    r_sum[r_bit] <= w_nand;
            4'd8:    r_c          <= w_nand;
            default: r_c          <= r_c;
          endcase
          if (w_last_step) begin
            r_step <= '0;
            if (w_last_bit) begin
              r_bit  <= '0;
              r_cout <= w_nand;
              r_busy <= 1'b0;
            end else begin
              r_bit  <= r_bit + BIT_W'(1);
            end
          end else begin
            r_step <= r_step + 4'd1;
          end
        end
        DONE:    r_busy <= 1'b0;
        default: r_busy <= 1'b0;
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign sum   = r_sum;
  assign c_out = r_cout;

endmodule

// File: doc/nand_seq_adder.md
NAND_SEQ_ADDER -- requirements
Module: nand_seq_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and sum width (legal range 1..32).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1 bit, request to begin an addition.
REQ-005 SHALL have ports a and b, input, WIDTH bits each, the operands.
REQ-006 SHALL have port c_in, input, 1 bit, the carry-in.
REQ-007 SHALL have port busy, output, 1 bit, high while an addition is in progress.
REQ-008 SHALL have port done, output, 1 bit, a one-cycle completion pulse.
REQ-009 SHALL have ports sum (output, WIDTH bits, result) and c_out (output, 1 bit, final carry).

Function
REQ-010 SHALL compute a + b + c_in by time-multiplexing exactly one shared 2-input NAND evaluator, one NAND evaluation per cycle.
REQ-011 SHALL implement a state machine IDLE -> EVAL -> DONE -> IDLE.
REQ-012 SHALL, in IDLE with start=1, latch a, b and c_in, clear the step and bit counters, set busy=1 and enter EVAL on the same edge.
REQ-013 SHALL ignore start while busy=1; operand changes during EVAL SHALL have no effect.
REQ-014 SHALL, for bit i with running carry c, run steps 0..8 in order, each result written to a scratch register:
- s0 n1=NAND(a_i,b_i)
- s1 n2=NAND(a_i,n1)
- s2 n3=NAND(b_i,n1)
- s3 x=NAND(n2,n3)
- s4 n5=NAND(x,c)
- s5 n6=NAND(x,n5)
- s6 n7=NAND(c,n5)
- s7 sum_i=NAND(n6,n7)
- s8 c=NAND(n1,n5)
REQ-015 SHALL, after step 8, reset the step counter to 0 and advance the bit counter; after step 8 of bit WIDTH-1, enter DONE.
REQ-016 SHALL take exactly 9*WIDTH EVAL cycles (72 for WIDTH=8).
REQ-017 SHALL, in DONE, drive done=1 for exactly one cycle with busy=0, then return to IDLE. done SHALL rise 9*WIDTH+1 cycles after the accepting edge (73 for WIDTH=8).
REQ-018 SHALL hold sum and c_out stable from DONE until the next accepted start, and SHALL update sum bit i only at step 7 of bit i.
REQ-019 SHALL accept a start asserted in the DONE cycle on the following cycle only; back-to-back accepts are therefore at least 9*WIDTH+2 cycles apart.

Reset
REQ-020 SHALL, on reset=1, immediately force state=IDLE, busy=0, done=0, sum=0, c_out=0, counters=0 and scratch=0.
REQ-021 SHALL, on reset asserted mid-operation, abort the addition with no done pulse and discard any partial result.

Configuration
REQ-022 SHALL, with macro NAND_SEQ_SUB_EN defined, add an input port sub (1 bit) latched with the operands.
- sub=1: b is bit-inverted and the carry-in is forced to 1 (c_in ignored), giving a - b with c_out=1 meaning no borrow.
- sub=0: behaviour is unchanged.
REQ-023 SHALL, without NAND_SEQ_SUB_EN, have no sub port and perform addition only.

Structure
REQ-024 SHALL place in package nand_seq_pkg:
- the state enum (IDLE, EVAL, DONE)
- constant NAND_STEPS=9
- the step-index width constant.
REQ-025 SHALL instantiate one combinational sub-module nand_unit. Its two 4-bit inputs are zero-extended single bits; its output is 0 only when both LSBs are 1.

Verification
REQ-026 SHALL check: a=8'h00, b=8'h00, c_in=0 -> sum=8'h00, c_out=0, done 73 cycles after accept.
REQ-027 SHALL check: a=8'hFF, b=8'h01, c_in=0 -> sum=8'h00, c_out=1; a=8'hA5, b=8'h5A, c_in=1 -> sum=8'h00, c_out=1.
REQ-028 SHALL check: a=8'h7F, b=8'h01 accepted, then start held with a=8'h11 during EVAL -> single done, sum=8'h80, c_out=0, busy never drops early.
REQ-029 SHALL check: reset pulsed 30 cycles after accept -> busy=0, sum=0, no done pulse, next start computes correctly.
REQ-030 SHALL check with NAND_SEQ_SUB_EN: sub=1, a=8'h05, b=8'h07 -> sum=8'hFE, c_out=0; a=8'h07, b=8'h05 -> sum=8'h02, c_out=1.
